// File: rtl/fft_pkg.sv
// Shared constants, reader FSM encoding and the bit-reversal helper for the FFT input stage.
package fft_pkg;

  localparam int unsigned FFT_LOG2N  = 8;
  localparam int unsigned FFT_N      = 1 << FFT_LOG2N;
  localparam int unsigned FFT_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StBusy
  } rd_state_e;

  function automatic logic [FFT_LOG2N-1:0] bitrev(input logic [FFT_LOG2N-1:0] a);
    logic [FFT_LOG2N-1:0] r;
    for (int i = 0; i < int'(FFT_LOG2N); i++) begin
      r[i] = a[FFT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_dp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
module fft_dp_ram #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WIDTH  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft_in_pingpong_buf.sv
// FFT input stage: bit-reversed writes into a two-bank ping-pong buffer, frame hand-off to
// the core via frame_start, natural-order reads of the bank the core owns.
module fft_in_pingpong_buf
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W,
  parameter int unsigned LOG2N  = FFT_LOG2N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              frame_start,
  input  logic              core_done,
  input  logic [LOG2N-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_re,
  output logic [DATA_W-1:0] rd_im,
  output logic              rd_bank,
  output logic [1:0]        bank_full
);

  logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       bank_full_q, bank_full_d;
  rd_state_e        state_q, state_d;

  logic accept, frame_end, bank_release;
  logic [2*DATA_W-1:0] rd_data;

  // Registers only: in_ready never depends on in_valid.
  assign in_ready     = ~bank_full_q[wr_bank_q];
  assign accept       = in_valid & in_ready;
  assign frame_end    = accept & (&wr_cnt_q);
  assign bank_release = (state_q == StBusy) & core_done;

  always_comb begin
    wr_cnt_d    = accept ? wr_cnt_q + 1'b1 : wr_cnt_q;
    wr_bank_d   = wr_bank_q ^ frame_end;
    rd_bank_d   = rd_bank_q ^ bank_release;
    bank_full_d = bank_full_q;
    // Frame end and release always target different banks, so both may apply.
    if (frame_end) begin
      bank_full_d[wr_bank_q] = 1'b1;
    end
    if (bank_release) begin
      bank_full_d[rd_bank_q] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= 2'b00;
      state_q     <= StIdle;
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      bank_full_q <= bank_full_d;
      state_q     <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bank_full_q[rd_bank_q]) state_d = StStart;
      StStart: state_d = StBusy;
      StBusy:  if (core_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    if (state_q == StStart) begin
      frame_start = 1'b1;
    end
  end

  assign rd_bank   = rd_bank_q;
  assign bank_full = bank_full_q;

  fft_dp_ram #(
    .ADDR_W(LOG2N + 1),
    .WIDTH (2 * DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (accept),
    .waddr({wr_bank_q, bitrev(wr_cnt_q)}),
    .wdata({in_re, in_im}),
    .raddr({rd_bank_q, rd_addr}),
    .rdata(rd_data)
  );

  assign rd_re = rd_data[2*DATA_W-1:DATA_W];
  assign rd_im = rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_fft_in_pingpong_buf.sv
// Directed bench for the FFT input ping-pong buffer.
module tb_fft_in_pingpong_buf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re, in_im;
  logic        frame_start;
  logic        core_done;
  logic [7:0]  rd_addr;
  logic [15:0] rd_re, rd_im;
  logic        rd_bank;
  logic [1:0]  bank_full;

  int tests = 0;
  int fails = 0;
  int fs_cnt = 0;
  int fs_base;
  int acc;

  fft_in_pingpong_buf #(
    .DATA_W(16),
    .LOG2N (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_re      (in_re),
    .in_im      (in_im),
    .frame_start(frame_start),
    .core_done  (core_done),
    .rd_addr    (rd_addr),
    .rd_re      (rd_re),
    .rd_im      (rd_im),
    .rd_bank    (rd_bank),
    .bank_full  (bank_full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_start) fs_cnt <= fs_cnt + 1;

  function automatic logic [7:0] rev8(input logic [7:0] a);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = a[7-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] re, input logic [15:0] im);
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    step();
  endtask

  task automatic pulse_done();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    core_done = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] re,
                          input logic [15:0] im);
    rd_addr = a;
    step();
    check({tag, "_re"}, 32'(rd_re), 32'(re));
    check({tag, "_im"}, 32'(rd_im), 32'(im));
  endtask

  initial begin
    in_re = '0;
    in_im = '0;
    rd_addr = '0;
    do_reset();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_bank_full", 32'(bank_full), 32'd0);

    // Test 2: one back-to-back frame, re=k im=-k
    fs_base = fs_cnt;
    for (int k = 0; k < 256; k++) push(16'(k), 16'(-k));
    in_valid = 1'b0;
    check("t2_full_T1", 32'(bank_full), 32'b01);
    check("t2_fs_T1", 32'(frame_start), 32'd0);
    step();
    check("t2_fs_T2", 32'(frame_start), 32'd1);
    step();
    check("t2_fs_T3", 32'(frame_start), 32'd0);
    check("t2_fs_count", 32'(fs_cnt - fs_base), 32'd1);
    read_chk("t2_rd1", 8'd1, 16'd128, 16'hFF80);
    read_chk("t2_rd3", 8'd3, 16'd192, 16'hFF40);
    read_chk("t2_rd0", 8'd0, 16'd0, 16'd0);
    read_chk("t2_rd255", 8'd255, 16'd255, 16'hFF01);

    // Test 6: release bank 0, then a spurious core_done in IDLE
    pulse_done();
    check("t6_rel_bank", 32'(rd_bank), 32'd1);
    check("t6_rel_full", 32'(bank_full), 32'd0);
    pulse_done();
    step();
    check("t6_spur_bank", 32'(rd_bank), 32'd1);
    check("t6_spur_full", 32'(bank_full), 32'd0);
    check("t6_spur_ready", 32'(in_ready), 32'd1);

    // Test 1: reset in the middle of a partial frame
    for (int k = 0; k < 100; k++) push(16'h7000, 16'h7000);
    rst_n = 1'b0;
    #1;
    check("t1_ready", 32'(in_ready), 32'd1);
    check("t1_fs", 32'(frame_start), 32'd0);
    check("t1_full", 32'(bank_full), 32'd0);
    check("t1_rd_bank", 32'(rd_bank), 32'd0);
    check("t1_rd_re", 32'(rd_re), 32'd0);
    check("t1_rd_im", 32'(rd_im), 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Test 3: 512 samples with no core_done -> both banks full, writer stalls
    fs_base = fs_cnt;
    for (int k = 0; k < 255; k++) push(16'(k), 16'(k));
    check("t3_not_full_255", 32'(bank_full), 32'd0);
    for (int k = 255; k < 512; k++) push(16'(k), 16'(k));
    check("t3_full11", 32'(bank_full), 32'b11);
    check("t3_ready0", 32'(in_ready), 32'd0);
    in_re = 16'd512;
    in_im = 16'd512;
    for (int i = 0; i < 4; i++) step();
    check("t3_still_held", 32'(in_ready), 32'd0);
    check("t3_fs_count1", 32'(fs_cnt - fs_base), 32'd1);
    pulse_done();
    check("t3_ready_after_rel", 32'(in_ready), 32'd1);
    check("t3_full_after_rel", 32'(bank_full), 32'b10);
    check("t3_rd_bank1", 32'(rd_bank), 32'd1);
    step();
    in_valid = 1'b0;
    read_chk("t3_b1_rd1", 8'd1, 16'd384, 16'd384);
    check("t3_fs_count2", 32'(fs_cnt - fs_base), 32'd2);
    pulse_done();
    check("t3_rd_bank0", 32'(rd_bank), 32'd0);
    check("t3_full_partial", 32'(bank_full), 32'd0);
    read_chk("t3_b0_rd0", 8'd0, 16'd512, 16'd512);
    read_chk("t3_b0_rd1", 8'd1, 16'd128, 16'd128);

    // Test 4: core_done coincides with the last sample of bank 1
    do_reset();
    fs_base = fs_cnt;
    for (int k = 0; k < 256; k++) push(16'(k), 16'(k));
    for (int k = 0; k < 255; k++) push(16'(k + 1000), 16'(k));
    check("t4_busy_bank", 32'(bank_full), 32'b01);
    core_done = 1'b1;
    push(16'd1255, 16'd255);
    core_done = 1'b0;
    in_valid = 1'b0;
    check("t4_full", 32'(bank_full), 32'b10);
    check("t4_ready", 32'(in_ready), 32'd1);
    check("t4_rd_bank", 32'(rd_bank), 32'd1);
    check("t4_fs_T1", 32'(frame_start), 32'd0);
    step();
    check("t4_fs_T2", 32'(frame_start), 32'd1);
    step();
    check("t4_fs_count", 32'(fs_cnt - fs_base), 32'd2);
    read_chk("t4_b1_rd1", 8'd1, 16'd1128, 16'd128);

    // Test 5: gappy input produces the same bank contents as test 2
    do_reset();
    fs_base = fs_cnt;
    acc = 0;
    while (acc < 256) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_re = 16'(acc);
        in_im = 16'(-acc);
        acc++;
      end else begin
        in_valid = 1'b0;
        in_re = 16'hDEAD;
        in_im = 16'hBEEF;
      end
      if (acc == 256) check("t5_not_full_255", 32'(bank_full), 32'd0);
      step();
    end
    in_valid = 1'b0;
    check("t5_full", 32'(bank_full), 32'b01);
    step();
    check("t5_fs_T2", 32'(frame_start), 32'd1);
    read_chk("t5_rd1", 8'd1, 16'(rev8(8'd1)), 16'(-int'(rev8(8'd1))));
    read_chk("t5_rd3", 8'd3, 16'(rev8(8'd3)), 16'(-int'(rev8(8'd3))));
    read_chk("t5_rd100", 8'd100, 16'(rev8(8'd100)), 16'(-int'(rev8(8'd100))));
    read_chk("t5_rd254", 8'd254, 16'(rev8(8'd254)), 16'(-int'(rev8(8'd254))));
    check("t5_fs_count", 32'(fs_cnt - fs_base), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
